// File: rtl/rgb2ycbcr_pkg.sv
// Shared mode encodings, Q8 matrix coefficients and offsets for the RGB->YCbCr pipe.
package rgb2ycbcr_pkg;

  typedef enum logic [1:0] {
    MODE_601F = 2'd0,
    MODE_709F = 2'd1,
    MODE_601S = 2'd2,
    MODE_RSVD = 2'd3
  } mode_e;

  localparam int PIPE_LAT = 4;

  // Row order: Y(r,g,b), Cb(r,g,b), Cr(r,g,b)
  localparam int COEF_601F [0:8] = '{ 77, 150,  29, -43, -85, 128, 128, -107, -21};
  localparam int COEF_709F [0:8] = '{ 54, 183,  18, -29, -99, 128, 128, -116, -12};
  localparam int COEF_601S [0:8] = '{ 66, 129,  25, -38, -74, 112, 112,  -94, -18};

  localparam int Y_OFS8_FULL   = 0;
  localparam int Y_OFS8_STUDIO = 16;
  localparam int C_OFS8        = 128;

  function automatic mode_e mode_sanitize(input logic [1:0] m);
    return (m == 2'd3) ? MODE_601F : mode_e'(m);
  endfunction

  function automatic int coef_q8(input mode_e m, input int idx);
    case (m)
      MODE_709F: return COEF_709F[idx];
      MODE_601S: return COEF_601S[idx];
      default:   return COEF_601F[idx];
    endcase
  endfunction

endpackage

// File: rtl/rgb2ycbcr_if.sv
// Pixel stream bundle: RGB + syncs toward the converter, YCbCr + delayed syncs back.
interface rgb2ycbcr_if #(parameter int DW = 8);
  logic [DW-1:0] r_in, g_in, b_in;
  logic          vs_in, hs_in, de_in;
  logic [DW-1:0] y_out, u_out, v_out;
  logic          vs_out, hs_out, de_out;

  modport master (
    output r_in, g_in, b_in, vs_in, hs_in, de_in,
    input  y_out, u_out, v_out, vs_out, hs_out, de_out
  );

  modport slave (
    input  r_in, g_in, b_in, vs_in, hs_in, de_in,
    output y_out, u_out, v_out, vs_out, hs_out, de_out
  );
endinterface

// File: rtl/rgb2ycbcr_pipe_luma_enh.sv
// Final stage: luma dark-up/light-down enhancement, clamp, blanking insertion and output register.
module ycbcr_luma_enh
  import rgb2ycbcr_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] y_in,
  input  logic [DW-1:0] u_in,
  input  logic [DW-1:0] v_in,
  input  logic          vs_in,
  input  logic          hs_in,
  input  logic          de_in,
  input  logic          fill_in,
  input  logic          studio,
  input  logic          darkup_sw,
  input  logic [DW-1:0] darkup_num,
  input  logic          lightdown_sw,
  input  logic [DW-1:0] lightdown_num,
  output logic [DW-1:0] y_out,
  output logic [DW-1:0] u_out,
  output logic [DW-1:0] v_out,
  output logic          vs_out,
  output logic          hs_out,
  output logic          de_out
);

  localparam int EW = DW + 2;
  localparam logic [DW-1:0] C_MID   = DW'(C_OFS8 << (DW - 8));
  localparam logic [DW-1:0] Y_BLK_S = DW'(Y_OFS8_STUDIO << (DW - 8));

  logic signed [EW-1:0] ys, dn, ln, add, sub, yr;
  logic [DW-1:0]        y_sat;

  always_comb begin
    ys  = $signed(EW'(y_in));
    dn  = $signed(EW'(darkup_num));
    ln  = $signed(EW'(lightdown_num));
    add = '0;
    sub = '0;
    if (darkup_sw && (y_in < darkup_num))
      add = (dn - ys) >>> 3;
    if (lightdown_sw && (y_in > lightdown_num))
      sub = (ys - ln) >>> 3;
    // both corrections may apply together; the headroom bits keep the sum from wrapping
    yr = ys + add - sub;
    if (yr < 0)
      y_sat = '0;
    else if (yr > $signed(EW'({DW{1'b1}})))
      y_sat = '1;
    else
      y_sat = yr[DW-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_out  <= '0;
      u_out  <= '0;
      v_out  <= '0;
      vs_out <= 1'b0;
      hs_out <= 1'b0;
      de_out <= 1'b0;
    end else begin
      vs_out <= vs_in;
      hs_out <= hs_in;
      de_out <= de_in;
      // slots not yet refilled since reset stay all-zero instead of showing blanking levels
      if (!fill_in) begin
        y_out <= '0;
        u_out <= '0;
        v_out <= '0;
      end else if (!de_in) begin
        y_out <= studio ? Y_BLK_S : '0;
        u_out <= C_MID;
        v_out <= C_MID;
      end else begin
        y_out <= y_sat;
        u_out <= u_in;
        v_out <= v_in;
      end
    end
  end

endmodule

// File: rtl/rgb2ycbcr_pipe.sv
// Four-stage RGB->YCbCr converter with frame-synchronous matrix select and luma enhancement.
// Optional per-frame luma statistics outputs: define RGB2YCBCR_LUMA_STATS_EN.
module rgb2ycbcr_pipe
  import rgb2ycbcr_pkg::*;
#(
  parameter int DW = 8,
  parameter int CF = 8
) (
  input  logic          clk,
  input  logic          rst,
  rgb2ycbcr_if.slave    pix,
  input  logic [1:0]    mode,
  input  logic          darkup_sw,
  input  logic [DW-1:0] darkup_num,
  input  logic          lightdown_sw,
  input  logic [DW-1:0] lightdown_num,
  output logic [1:0]    mode_active
`ifdef RGB2YCBCR_LUMA_STATS_EN
  ,
  output logic [DW-1:0] stat_ymin,
  output logic [DW-1:0] stat_ymax,
  output logic [23:0]   stat_cnt,
  output logic          stat_valid
`endif
);

  localparam int CW = CF + 2;
  localparam int SW = DW + CF + 3;
  localparam int TW = SW + 2;

  logic  vs_prev;
  mode_e mode_cur, mode_nxt;

  // a mode written in the same cycle as the vs rise is used by that very pixel
  assign mode_nxt    = (pix.vs_in && !vs_prev) ? mode_sanitize(mode) : mode_cur;
  assign mode_active = mode_cur;

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_prev  <= 1'b0;
      mode_cur <= MODE_601F;
    end else begin
      vs_prev  <= pix.vs_in;
      mode_cur <= mode_nxt;
    end
  end

  logic signed [CW-1:0] coef [9];
  logic [DW-1:0]        px   [3];

  always_comb begin
    px[0] = pix.r_in;
    px[1] = pix.g_in;
    px[2] = pix.b_in;
    for (int i = 0; i < 9; i++)
      coef[i] = CW'(coef_q8(mode_nxt, i) * (1 << (CF - 8)));
  end

  logic signed [SW-1:0] prod_s1 [9];
  logic signed [SW-1:0] sum_s2  [3];
  logic [DW-1:0]        y_s3, u_s3, v_s3;
  logic [2:0]           vs_p, hs_p, de_p, fill_p;
  mode_e                mode_s1, mode_s2, mode_s3;

  function automatic logic [DW-1:0] round_clamp(input logic signed [SW-1:0] s, input int ofs8);
    logic signed [TW-1:0] acc;
    acc = TW'(s) + (TW'(ofs8) <<< (CF + DW - 8)) + (TW'(1) <<< (CF - 1));
    acc = acc >>> CF;
    if (acc < 0)
      return '0;
    else if (acc > TW'((1 << DW) - 1))
      return '1;
    else
      return acc[DW-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 9; i++) prod_s1[i] <= '0;
      for (int k = 0; k < 3; k++) sum_s2[k] <= '0;
      y_s3    <= '0;
      u_s3    <= '0;
      v_s3    <= '0;
      vs_p    <= '0;
      hs_p    <= '0;
      de_p    <= '0;
      fill_p  <= '0;
      mode_s1 <= MODE_601F;
      mode_s2 <= MODE_601F;
      mode_s3 <= MODE_601F;
    end else begin
      for (int k = 0; k < 3; k++)
        for (int j = 0; j < 3; j++)
          prod_s1[3*k+j] <= SW'($signed({1'b0, px[j]})) * SW'(coef[3*k+j]);
      for (int k = 0; k < 3; k++)
        sum_s2[k] <= prod_s1[3*k] + prod_s1[3*k+1] + prod_s1[3*k+2];
      y_s3 <= round_clamp(sum_s2[0], (mode_s2 == MODE_601S) ? Y_OFS8_STUDIO : Y_OFS8_FULL);
      u_s3 <= round_clamp(sum_s2[1], C_OFS8);
      v_s3 <= round_clamp(sum_s2[2], C_OFS8);
      vs_p    <= {vs_p[1:0], pix.vs_in};
      hs_p    <= {hs_p[1:0], pix.hs_in};
      de_p    <= {de_p[1:0], pix.de_in};
      fill_p  <= {fill_p[1:0], 1'b1};
      mode_s1 <= mode_nxt;
      mode_s2 <= mode_s1;
      mode_s3 <= mode_s2;
    end
  end

  logic [DW-1:0] y_o, u_o, v_o;
  logic          vs_o, hs_o, de_o;

  ycbcr_luma_enh #(.DW(DW)) u_enh (
    .clk           (clk),
    .rst           (rst),
    .y_in          (y_s3),
    .u_in          (u_s3),
    .v_in          (v_s3),
    .vs_in         (vs_p[2]),
    .hs_in         (hs_p[2]),
    .de_in         (de_p[2]),
    .fill_in       (fill_p[2]),
    .studio        (mode_s3 == MODE_601S),
    .darkup_sw     (darkup_sw),
    .darkup_num    (darkup_num),
    .lightdown_sw  (lightdown_sw),
    .lightdown_num (lightdown_num),
    .y_out         (y_o),
    .u_out         (u_o),
    .v_out         (v_o),
    .vs_out        (vs_o),
    .hs_out        (hs_o),
    .de_out        (de_o)
  );

  assign pix.y_out  = y_o;
  assign pix.u_out  = u_o;
  assign pix.v_out  = v_o;
  assign pix.vs_out = vs_o;
  assign pix.hs_out = hs_o;
  assign pix.de_out = de_o;

`ifdef RGB2YCBCR_LUMA_STATS_EN
  logic [DW-1:0] acc_min, acc_max;
  logic [23:0]   acc_cnt;
  logic          vs_o_d;

  // report and restart on the output-side frame edge, so stats match what left the block
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_min    <= '1;
      acc_max    <= '0;
      acc_cnt    <= '0;
      vs_o_d     <= 1'b0;
      stat_ymin  <= '0;
      stat_ymax  <= '0;
      stat_cnt   <= '0;
      stat_valid <= 1'b0;
    end else begin
      vs_o_d     <= vs_o;
      stat_valid <= 1'b0;
      if (vs_o && !vs_o_d) begin
        stat_ymin  <= acc_min;
        stat_ymax  <= acc_max;
        stat_cnt   <= acc_cnt;
        stat_valid <= 1'b1;
        acc_min    <= '1;
        acc_max    <= '0;
        acc_cnt    <= '0;
      end else if (de_o) begin
        if (y_o < acc_min) acc_min <= y_o;
        if (y_o > acc_max) acc_max <= y_o;
        if (acc_cnt != '1) acc_cnt <= acc_cnt + 24'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_rgb2ycbcr_pipe.sv
// Directed + random scoreboard bench for rgb2ycbcr_pipe (DW=8, CF=8).
module tb_rgb2ycbcr_pipe;

  localparam int DW = 8;
  localparam int CF_TAB [0:2][0:8] = '{
    '{ 77, 150,  29, -43, -85, 128, 128, -107, -21},
    '{ 54, 183,  18, -29, -99, 128, 128, -116, -12},
    '{ 66, 129,  25, -38, -74, 112, 112,  -94, -18}
  };

  typedef struct {
    int y, u, v;
    bit vs, hs, de;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    mode = 2'd0;
  logic [1:0]    mode_active;
  logic          darkup_sw = 1'b0, lightdown_sw = 1'b0;
  logic [DW-1:0] darkup_num = '0, lightdown_num = '0;
`ifdef RGB2YCBCR_LUMA_STATS_EN
  logic [DW-1:0] stat_ymin, stat_ymax;
  logic [23:0]   stat_cnt;
  logic          stat_valid;
`endif

  always #5 clk = ~clk;

  rgb2ycbcr_if #(.DW(DW)) pix ();

  rgb2ycbcr_pipe #(.DW(DW), .CF(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .pix           (pix),
    .mode          (mode),
    .darkup_sw     (darkup_sw),
    .darkup_num    (darkup_num),
    .lightdown_sw  (lightdown_sw),
    .lightdown_num (lightdown_num),
    .mode_active   (mode_active)
`ifdef RGB2YCBCR_LUMA_STATS_EN
    ,
    .stat_ymin     (stat_ymin),
    .stat_ymax     (stat_ymax),
    .stat_cnt      (stat_cnt),
    .stat_valid    (stat_valid)
`endif
  );

  int   checks = 0;
  int   failures = 0;
  exp_t q[$];
  int   m_act = 0;
  bit   m_vsp = 1'b0;
  int   sm_min = 255, sm_max = 0, sm_cnt = 0;
  int   rp_min = 0, rp_max = 0, rp_cnt = 0;
  bit   sm_pend = 1'b0, sm_prev_vs = 1'b0;

  function automatic int clamp255(int x);
    return (x < 0) ? 0 : ((x > 255) ? 255 : x);
  endfunction

  function automatic exp_t model(int r, int g, int b, bit vs, bit hs, bit de, int m);
    exp_t e;
    int   s [3];
    int   y, add, sub;
    for (int k = 0; k < 3; k++)
      s[k] = CF_TAB[m][3*k] * r + CF_TAB[m][3*k+1] * g + CF_TAB[m][3*k+2] * b;
    y   = clamp255((s[0] + ((m == 2) ? 16 : 0) * 256 + 128) >>> 8);
    e.u = clamp255((s[1] + 128 * 256 + 128) >>> 8);
    e.v = clamp255((s[2] + 128 * 256 + 128) >>> 8);
    add = (darkup_sw && y < int'(darkup_num)) ? (int'(darkup_num) - y) / 8 : 0;
    sub = (lightdown_sw && y > int'(lightdown_num)) ? (y - int'(lightdown_num)) / 8 : 0;
    e.y = clamp255(y + add - sub);
    if (!de) begin
      e.y = (m == 2) ? 16 : 0;
      e.u = 128;
      e.v = 128;
    end
    e.vs = vs;
    e.hs = hs;
    e.de = de;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    chk("mode_active", 32'(mode_active), 32'(m_act));
    if (q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL scoreboard_underflow observed=0 expected=1");
    end else begin
      e = q.pop_front();
      chk("y_out", 32'(pix.y_out), 32'(e.y));
      chk("u_out", 32'(pix.u_out), 32'(e.u));
      chk("v_out", 32'(pix.v_out), 32'(e.v));
      chk("vs_out", 32'(pix.vs_out), 32'(e.vs));
      chk("hs_out", 32'(pix.hs_out), 32'(e.hs));
      chk("de_out", 32'(pix.de_out), 32'(e.de));
`ifdef RGB2YCBCR_LUMA_STATS_EN
      chk("stat_valid", 32'(stat_valid), 32'(sm_pend));
      if (sm_pend) begin
        chk("stat_ymin", 32'(stat_ymin), 32'(rp_min));
        chk("stat_ymax", 32'(stat_ymax), 32'(rp_max));
        chk("stat_cnt", 32'(stat_cnt), 32'(rp_cnt));
      end
      sm_pend = 1'b0;
      if (e.vs && !sm_prev_vs) begin
        rp_min  = sm_min;
        rp_max  = sm_max;
        rp_cnt  = sm_cnt;
        sm_pend = 1'b1;
        sm_min  = 255;
        sm_max  = 0;
        sm_cnt  = 0;
      end else if (e.de) begin
        if (e.y < sm_min) sm_min = e.y;
        if (e.y > sm_max) sm_max = e.y;
        sm_cnt++;
      end
      sm_prev_vs = e.vs;
`endif
    end
  endtask

  task automatic drive(input int r, input int g, input int b, input bit vs, input bit hs, input bit de);
    int m_eff;
    m_eff = (vs && !m_vsp) ? ((mode == 2'd3) ? 0 : int'(mode)) : m_act;
    q.push_back(model(r, g, b, vs, hs, de, m_eff));
    m_act = m_eff;
    m_vsp = vs;
    pix.r_in  = 8'(r);
    pix.g_in  = 8'(g);
    pix.b_in  = 8'(b);
    pix.vs_in = vs;
    pix.hs_in = hs;
    pix.de_in = de;
    tick();
  endtask

  task automatic idle(input int n);
    repeat (n) drive(200, 10, 10, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input int n);
    exp_t z;
    rst = 1'b1;
    pix.r_in = '0; pix.g_in = '0; pix.b_in = '0;
    pix.vs_in = 1'b0; pix.hs_in = 1'b0; pix.de_in = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
      chk("rst_y", 32'(pix.y_out), 0);
      chk("rst_u", 32'(pix.u_out), 0);
      chk("rst_v", 32'(pix.v_out), 0);
      chk("rst_syncs", 32'({pix.vs_out, pix.hs_out, pix.de_out}), 0);
      chk("rst_mode_active", 32'(mode_active), 0);
`ifdef RGB2YCBCR_LUMA_STATS_EN
      chk("rst_stats", 32'({stat_ymin, stat_ymax, stat_valid}), 0);
      chk("rst_stat_cnt", 32'(stat_cnt), 0);
`endif
    end
    rst = 1'b0;
    q.delete();
    z = '{y: 0, u: 0, v: 0, vs: 1'b0, hs: 1'b0, de: 1'b0};
    repeat (3) q.push_back(z);
    m_act = 0;
    m_vsp = 1'b0;
    sm_min = 255; sm_max = 0; sm_cnt = 0;
    sm_pend = 1'b0; sm_prev_vs = 1'b0;
  endtask

  initial begin
    int r, g, b;
    pix.r_in = '0; pix.g_in = '0; pix.b_in = '0;
    pix.vs_in = 1'b0; pix.hs_in = 1'b0; pix.de_in = 1'b0;
    do_reset(3);

    // BT.601 full: white, black, primaries, then a blanked pixel
    mode = 2'd0;
    drive(0, 0, 0, 1, 0, 0);
    drive(255, 255, 255, 0, 1, 1);
    drive(0, 0, 0, 0, 1, 1);
    drive(255, 0, 0, 0, 1, 1);
    drive(0, 255, 0, 0, 1, 1);
    drive(0, 0, 255, 0, 1, 1);
    drive(200, 10, 10, 0, 0, 0);
    // mode change mid-frame must wait for the next vs rise
    mode = 2'd1;
    drive(0, 255, 0, 0, 1, 1);
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0);
    drive(0, 255, 0, 0, 1, 1);
    drive(255, 255, 255, 0, 1, 1);
    // studio range
    mode = 2'd2;
    drive(0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 1, 1);
    drive(255, 0, 0, 0, 1, 1);
    drive(200, 10, 10, 0, 0, 0);
    // reserved mode behaves as BT.601 full
    mode = 2'd3;
    drive(0, 0, 0, 1, 0, 0);
    drive(0, 255, 0, 0, 1, 1);
    idle(4);

    // enhancement
    darkup_sw = 1'b1; darkup_num = 8'd64;
    drive(16, 16, 16, 0, 1, 1);
    drive(100, 100, 100, 0, 1, 1);
    idle(4);
    darkup_sw = 1'b0; lightdown_sw = 1'b1; lightdown_num = 8'd200;
    drive(255, 255, 255, 0, 1, 1);
    drive(150, 150, 150, 0, 1, 1);
    idle(4);
    darkup_sw = 1'b1; darkup_num = 8'd255; lightdown_num = 8'd0;
    drive(0, 0, 0, 0, 1, 1);
    drive(255, 255, 255, 0, 1, 1);
    drive(128, 128, 128, 0, 1, 1);
    drive(1, 0, 2, 0, 1, 1);
    idle(4);

    // random frames with random matrix and enhancement settings
    for (int f = 0; f < 4; f++) begin
      darkup_sw     = 1'($urandom_range(0, 1));
      lightdown_sw  = 1'($urandom_range(0, 1));
      darkup_num    = 8'($urandom_range(0, 255));
      lightdown_num = 8'($urandom_range(0, 255));
      mode          = 2'($urandom_range(0, 3));
      drive(0, 0, 0, 1, 0, 0);
      for (int p = 0; p < 12; p++) begin
        r = int'($urandom_range(0, 255));
        g = int'($urandom_range(0, 255));
        b = int'($urandom_range(0, 255));
        drive(r, g, b, 0, (p % 4) != 3, $urandom_range(0, 3) != 0);
      end
      idle(4);
    end
    darkup_sw = 1'b0; lightdown_sw = 1'b0;

    // reset in the middle of a line flushes everything in flight
    mode = 2'd2;
    drive(0, 0, 0, 1, 0, 0);
    drive(255, 0, 0, 0, 1, 1);
    drive(255, 0, 0, 0, 1, 1);
    do_reset(2);
    mode = 2'd0;
    drive(90, 90, 90, 0, 1, 1);
    drive(40, 40, 40, 0, 1, 1);
    idle(4);

    // 4x2 luma frame, then an empty frame
    drive(0, 0, 0, 1, 0, 0);
    drive(10, 10, 10, 0, 1, 1);
    drive(50, 50, 50, 0, 1, 1);
    drive(200, 200, 200, 0, 1, 1);
    drive(120, 120, 120, 0, 1, 1);
    drive(0, 0, 0, 0, 0, 0);
    drive(30, 30, 30, 0, 1, 1);
    drive(90, 90, 90, 0, 1, 1);
    drive(150, 150, 150, 0, 1, 1);
    drive(60, 60, 60, 0, 1, 1);
    idle(2);
    drive(0, 0, 0, 1, 0, 0);
    idle(3);
    drive(0, 0, 0, 1, 0, 0);
    idle(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
